seg_display_mux: RTL and testbench

Parametrised time-multiplexed driver for common-anode 7-segment displays: generalises the fixed 4-digit hex scanner to `DIGITS` digits, configurable slot and guard timing, per-digit decimal point and blanking, and frame-coherent sampling. Sits between the game/score logic and the board's `seg`/`an` pins. All outputs are registered.

---
 rtl/seg_display_pkg.sv | 46 ++++
 rtl/seg_display_mux_hex_decode.sv | 19 +
 rtl/seg_display_mux.sv | 158 +++++++++++++++
 tb/tb_seg_display_mux.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// ============================================================================
// Module   : seg_display_pkg
// Purpose  : Shared segment constants, hex-to-segment table, parameter check.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg_display_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Active-low cathodes, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  function automatic bit params_legal(input int unsigned digits,
                                      input int unsigned slot_cycles,
                                      input int unsigned guard_cycles);
    return (digits >= 1) && (digits <= 8) && (guard_cycles >= 1) &&
           (slot_cycles >= 2 * guard_cycles + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_display_mux_hex_decode.sv
// ============================================================================
// Module   : seg_hex_decode
// Purpose  : Combinational nibble to active-low 7-segment decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

`default_nettype wire

// File: rtl/seg_display_mux.sv
// ============================================================================
// Module   : seg_display_mux
// Purpose  : Time-multiplexed common-anode 7-segment scanner with guard bands,
//            per-digit dp/blank and frame-coherent input snapshots.
//            Optional macro SEGDISP_LZB_EN enables leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SLOT_CYCLES  = 100,
  parameter int unsigned GUARD_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  empty_i,
  output logic [6:0]            seg_o,
  output logic                  dp_out_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_start_o
);

  localparam int unsigned C_SW = $clog2(SLOT_CYCLES);
  localparam int unsigned C_DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (!params_legal(DIGITS, SLOT_CYCLES, GUARD_CYCLES)) begin : g_bad_params
      $error("seg_display_mux: illegal DIGITS/SLOT_CYCLES/GUARD_CYCLES");
    end
  endgenerate

  logic [C_SW-1:0]     s_q, s_d;
  logic [C_DW-1:0]     d_q, d_d;
  logic [4*DIGITS-1:0] num_snap_q, num_snap_d;
  logic [DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [DIGITS-1:0]   blank_snap_q, blank_snap_d;
  logic                lit_q, lit_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic                fs_q, fs_d;

  // Digit 0 decodes from the live inputs because they become the new snapshot.
  logic                first_digit;
  logic [4*DIGITS-1:0] src_num;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blank;
  logic [6:0]          hex_seg;
  logic                digit_blank;

  assign first_digit = (d_q == '0);
  assign src_num     = first_digit ? number_i : num_snap_q;
  assign src_dp      = first_digit ? dp_i     : dp_snap_q;
  assign src_blank   = first_digit ? blank_i  : blank_snap_q;

  seg_hex_decode u_hex_decode (
    .nibble_i (src_num[4*d_q +: 4]),
    .seg_o    (hex_seg)
  );

`ifdef SEGDISP_LZB_EN
  logic [C_DW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (src_num[4*i +: 4] != 4'h0) msd = C_DW'(i);
    end
  end
  assign digit_blank = src_blank[d_q] | (d_q > msd);
`else
  assign digit_blank = src_blank[d_q];
`endif

  always_comb begin
    s_d          = (s_q == C_SW'(SLOT_CYCLES - 1)) ? '0 : s_q + C_SW'(1);
    d_d          = d_q;
    num_snap_d   = num_snap_q;
    dp_snap_d    = dp_snap_q;
    blank_snap_d = blank_snap_q;
    lit_d        = lit_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_out_d     = dp_out_q;
    fs_d         = 1'b0;

    if (s_q == C_SW'(SLOT_CYCLES - 1)) begin
      d_d = (d_q == C_DW'(DIGITS - 1)) ? '0 : d_q + C_DW'(1);
    end

    if (s_q == '0) begin
      an_d  = '1;
      lit_d = ~digit_blank;
      if (empty_i) begin
        seg_d    = SEG_DASH;
        dp_out_d = 1'b1;
      end else if (digit_blank) begin
        seg_d    = SEG_OFF;
        dp_out_d = 1'b1;
      end else begin
        seg_d    = hex_seg;
        dp_out_d = ~src_dp[d_q];
      end
      if (first_digit) begin
        num_snap_d   = number_i;
        dp_snap_d    = dp_i;
        blank_snap_d = blank_i;
        fs_d         = 1'b1;
      end
    end

    if ((s_q == C_SW'(GUARD_CYCLES)) && lit_q) begin
      an_d = ~(DIGITS'(1) << d_q);
    end
    if (s_q == C_SW'(SLOT_CYCLES - GUARD_CYCLES)) begin
      an_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q          <= '0;
      d_q          <= '0;
      num_snap_q   <= '0;
      dp_snap_q    <= '0;
      blank_snap_q <= '0;
      lit_q        <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_out_q     <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      s_q          <= s_d;
      d_q          <= d_d;
      num_snap_q   <= num_snap_d;
      dp_snap_q    <= dp_snap_d;
      blank_snap_q <= blank_snap_d;
      lit_q        <= lit_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_o         = seg_q;
  assign dp_out_o      = dp_out_q;
  assign an_o          = an_q;
  assign frame_start_o = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_mux.sv
// ============================================================================
// Module   : tb_seg_display_mux
// Purpose  : Self-checking bench for seg_display_mux against a cycle-index model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SLOT   = 100;
  localparam int unsigned GUARD  = 10;
  localparam int unsigned FRAME  = DIGITS * SLOT;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] number;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                empty;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an;
  logic                frame_start;

  always #5 clk = ~clk;

  seg_display_mux #(
    .DIGITS       (DIGITS),
    .SLOT_CYCLES  (SLOT),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .number_i      (number),
    .dp_i          (dp),
    .blank_i       (blank),
    .empty_i       (empty),
    .seg_o         (seg),
    .dp_out_o      (dp_out),
    .an_o          (an),
    .frame_start_o (frame_start)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: k counts non-reset edges since the last reset; every output is a
  // function of k and the inputs seen at the relevant slot/frame boundary.
  int                  k;
  logic [4*DIGITS-1:0] snap_num;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_blank;
  logic                e_lit;
  logic [6:0]          e_seg;
  logic                e_dp;
  logic [DIGITS-1:0]   e_an;
  logic                e_fs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic bit model_blanked(input int dg);
    int msd;
    bit b;
    b = snap_blank[dg];
`ifdef SEGDISP_LZB_EN
    msd = 0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (snap_num[4*i +: 4] != 4'h0) msd = i;
    if (dg > msd) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic step();
    int s;
    int dg;
    @(posedge clk);
    if (rst) begin
      k          = 0;
      snap_num   = '0;
      snap_dp    = '0;
      snap_blank = '0;
      e_lit      = 1'b0;
      e_seg      = 7'h7F;
      e_dp       = 1'b1;
      e_an       = '1;
      e_fs       = 1'b0;
    end else begin
      s    = k % SLOT;
      dg   = (k / SLOT) % DIGITS;
      e_fs = (k % FRAME == 0);
      if (s == 0) begin
        if (dg == 0) begin
          snap_num   = number;
          snap_dp    = dp;
          snap_blank = blank;
        end
        e_lit = !model_blanked(dg);
        if (empty) begin
          e_seg = 7'h3F;
          e_dp  = 1'b1;
        end else if (!e_lit) begin
          e_seg = 7'h7F;
          e_dp  = 1'b1;
        end else begin
          e_seg = hex_tbl[snap_num[4*dg +: 4]];
          e_dp  = ~snap_dp[dg];
        end
      end
      e_an = (e_lit && s >= int'(GUARD) && s < int'(SLOT - GUARD))
             ? ~(DIGITS'(1) << dg) : '1;
      k++;
    end
    #1;
    check_eq("an",          32'(an),          32'(e_an));
    check_eq("seg",         32'(seg),         32'(e_seg));
    check_eq("dp_out",      32'(dp_out),      32'(e_dp));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst    = 1'b1;
    number = 16'h1234;
    dp     = '0;
    blank  = '0;
    empty  = 1'b0;
    k      = 0;
    run(2);
    rst = 1'b0;

    // Change mid-frame during digit 1; digits 2,3 keep the old frame.
    run(150);
    number = 16'hABCD;
    run(2 * FRAME - 150);

    empty = 1'b1;
    run(FRAME);
    empty = 1'b0;

    blank = 4'b0100;
    dp    = 4'b0001;
    run(FRAME);
    blank = '0;
    dp    = '0;

    number = 16'h0050;
    run(FRAME);
    number = 16'h0000;
    run(FRAME);

    for (int i = 0; i < 6 * int'(FRAME); i++) begin
      if ($urandom_range(0, 149) == 0) number = 16'($urandom);
      if ($urandom_range(0, 299) == 0) dp     = 4'($urandom);
      if ($urandom_range(0, 299) == 0) blank  = 4'($urandom);
      if ($urandom_range(0, 499) == 0) empty  = ~empty;
      step();
    end
    empty = 1'b0;
    blank = '0;

    // Land the reset edge on digit 2, slot cycle 50.
    for (int i = 0; i < int'(FRAME) && (k % FRAME) != 2 * SLOT + 50; i++) step();
    check_eq("reset_position", 32'(k % FRAME), 32'(2 * SLOT + 50));
    rst = 1'b1;
    step();
    rst    = 1'b0;
    number = 16'($urandom);
    run(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
